// File: rtl/gtech_norn_pkg.sv
// Shared limits and elaboration-time helpers for the NOR/OR reduction pipeline.
package gtech_norn_pkg;

  localparam int unsigned N_IN_MAX   = 16;
  localparam int unsigned WIDTH_MAX  = 64;
  localparam int unsigned STAGES_MAX = 4;

  typedef enum logic {
    MODE_NOR = 1'b0,
    MODE_OR  = 1'b1
  } norn_mode_e;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Index of the first OR level evaluated in front of slice s.
  function automatic int unsigned stage_first(input int unsigned levels,
                                              input int unsigned stages,
                                              input int unsigned s);
    return (s * levels) / stages;
  endfunction

  // Number of OR levels evaluated in front of slice s; levels spread as evenly as possible.
  function automatic int unsigned stage_levels(input int unsigned levels,
                                               input int unsigned stages,
                                               input int unsigned s);
    return ((s + 1) * levels) / stages - (s * levels) / stages;
  endfunction

endpackage

// File: rtl/gtech_norn_stage.sv
// One register slice of the pipeline: valid flag, data register and ready/advance logic.
module gtech_norn_stage
  import gtech_norn_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [DW-1:0] data_in,
  input  logic          ready_down,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          ready
);

  // The slice can take a new beat when it is empty or its content leaves this cycle.
  assign ready = !valid || ready_down;

  // Load on ready; data only moves with a real beat so an empty slice keeps its old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= valid_in;
      if (valid_in) data <= data_in;
    end
  end

endmodule

// File: rtl/gtech_norn_pipe.sv
// Pipelined N-input bitwise NOR/OR with valid/ready handshake on both sides.
module gtech_norn_pipe
  import gtech_norn_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic                    CP,
  input  logic                    RST,
  input  logic [N_IN*WIDTH-1:0]   A,
  input  logic                    MODE,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [WIDTH-1:0]        Z,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY
);

  localparam int unsigned DW     = N_IN * WIDTH;
  localparam int unsigned MW     = DW + 1;
  localparam int unsigned LEVELS = clog2(N_IN);

  if (N_IN < 2 || N_IN > N_IN_MAX || WIDTH < 1 || WIDTH > WIDTH_MAX ||
      STAGES < 1 || STAGES > STAGES_MAX) begin : g_param_error
    $error("gtech_norn_pipe: parameter out of range (N_IN=%0d WIDTH=%0d STAGES=%0d)",
           N_IN, WIDTH, STAGES);
  end

  // Applies tree levels [first, first+count) to the packed operand vector. The operand
  // count at every level is recomputed from N_IN so each slice knows which slots are live;
  // an odd operand at the end of a level passes straight through, dead slots read as zero.
  function automatic logic [DW-1:0] or_levels(input logic [DW-1:0] v,
                                              input int unsigned first,
                                              input int unsigned count);
    logic [DW-1:0]    cur;
    logic [DW-1:0]    nxt;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    int unsigned      cnt;
    cur = v;
    cnt = N_IN;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      if (l >= first && l < first + count) begin
        nxt = '0;
        for (int unsigned j = 0; j < N_IN; j++) begin
          lo = WIDTH'(cur >> (2 * j * WIDTH));
          hi = (2 * j + 1 < cnt) ? WIDTH'(cur >> ((2 * j + 1) * WIDTH)) : '0;
          if (2 * j < cnt) nxt = nxt | (DW'(lo | hi) << (j * WIDTH));
        end
        cur = nxt;
      end
      cnt = (cnt + 1) / 2;
    end
    return cur;
  endfunction

  logic [MW-1:0] mid [STAGES];
  logic          vld [STAGES];
  logic          rdy [STAGES+1];

  assign rdy[STAGES] = OUT_READY;
  assign IN_READY    = rdy[0];
  assign OUT_VALID   = vld[STAGES-1];

  for (genvar s = 0; s < STAGES; s++) begin : g_slice
    localparam int unsigned FIRST = stage_first(LEVELS, STAGES, s);
    localparam int unsigned NLEV  = stage_levels(LEVELS, STAGES, s);

    logic [MW-1:0] src;
    logic          src_valid;
    logic [DW-1:0] red;

    if (s == 0) begin : g_head
      assign src       = {MODE, A};
      assign src_valid = IN_VALID;
    end else begin : g_body
      assign src       = mid[s-1];
      assign src_valid = vld[s-1];
    end

    // OR levels assigned to this slice, evaluated in front of its register.
    always_comb red = or_levels(src[DW-1:0], FIRST, NLEV);

    if (s < STAGES - 1) begin : g_mid
      gtech_norn_stage #(.DW(MW)) u_stage (
        .clk       (CP),
        .rst       (RST),
        .valid_in  (src_valid),
        .data_in   ({src[MW-1], red}),
        .ready_down(rdy[s+1]),
        .valid     (vld[s]),
        .data      (mid[s]),
        .ready     (rdy[s])
      );
    end else begin : g_last
      logic [WIDTH-1:0] result;

      // Inversion happens only here, using the MODE bit that travelled with the beat.
      always_comb begin
        result = red[WIDTH-1:0];
        if (norn_mode_e'(src[MW-1]) == MODE_NOR) result = ~red[WIDTH-1:0];
      end

      gtech_norn_stage #(.DW(WIDTH)) u_stage (
        .clk       (CP),
        .rst       (RST),
        .valid_in  (src_valid),
        .data_in   (result),
        .ready_down(rdy[s+1]),
        .valid     (vld[s]),
        .data      (Z),
        .ready     (rdy[s])
      );

      assign mid[s] = '0;
    end
  end

endmodule

// File: tb/tb_gtech_norn_pipe.sv
// Scoreboard bench for gtech_norn_pipe: default 4x8/2-stage instance plus a 3x1/1-stage instance.
module tb_gtech_norn_pipe;

  logic        cp = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_in = '0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  z;
  logic        out_valid;
  logic        out_ready = 1'b1;

  logic [2:0]  a3 = '0;
  logic        mode3 = 1'b0;
  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [0:0]  z3;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned n_in = 0;
  int unsigned n_out = 0;
  logic [7:0]  exp_q [$];
  logic        bp_stop = 1'b0;

  always #5 cp = ~cp;

  gtech_norn_pipe dut (
    .CP(cp), .RST(rst), .A(a_in), .MODE(mode), .IN_VALID(in_valid), .IN_READY(in_ready),
    .Z(z), .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  gtech_norn_pipe #(.N_IN(3), .WIDTH(1), .STAGES(1)) dut_odd (
    .CP(cp), .RST(rst), .A(a3), .MODE(mode3), .IN_VALID(in_valid3), .IN_READY(in_ready3),
    .Z(z3), .OUT_VALID(out_valid3), .OUT_READY(out_ready3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model4(input logic [31:0] a, input logic m);
    logic [7:0] r;
    r = a[7:0] | a[15:8] | a[23:16] | a[31:24];
    return m ? r : ~r;
  endfunction

  // Scoreboard: handshakes sampled mid-cycle, i.e. what the next rising edge will do.
  always @(negedge cp) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("spurious_out", {63'd0, out_valid}, 64'd0);
        else check("z_scoreboard", {56'd0, z}, {56'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) begin
        n_in++;
        exp_q.push_back(model4(a_in, mode));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic m);
    int unsigned n;
    n = 0;
    a_in = a;
    mode = m;
    in_valid = 1'b1;
    do begin
      @(negedge cp);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge cp);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic single(input logic [31:0] a, input logic m, input logic [7:0] expz, input string tag);
    out_ready = 1'b1;
    a_in = a;
    mode = m;
    in_valid = 1'b1;
    @(negedge cp);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge cp);
    #1;
    in_valid = 1'b0;
    check({tag, "_valid_t0"}, {63'd0, out_valid}, 64'd0);
    @(posedge cp);
    #1;
    check({tag, "_valid_t1"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_z"}, {56'd0, z}, {56'd0, expz});
    @(posedge cp);
    #1;
  endtask

  initial begin
    int unsigned in0;
    int unsigned out0;
    logic [7:0]  first_exp;

    // Reset for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge cp);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_z", {56'd0, z}, 64'd0);
    check("rst_odd_valid", {63'd0, out_valid3}, 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge cp);
    #1;

    // Single beats and all-zero / complementary operands.
    single(32'h0000_0001, 1'b0, 8'hFE, "single_nor");
    single(32'h0000_0001, 1'b1, 8'h01, "single_or");
    single(32'h0000_0000, 1'b0, 8'hFF, "zero_nor");
    single(32'hF00F_0000, 1'b0, 8'h00, "split_nor");

    // Backpressure: five beats against a stalled consumer.
    out_ready = 1'b0;
    in0 = n_in;
    first_exp = model4(32'h0000_0011, 1'b1);
    fork
      for (int i = 0; i < 5; i++) send(32'h0000_0011 << (i * 4), 1'(i % 2 == 0));
    join_none
    repeat (4) @(posedge cp);
    #2;
    check("bp_accepts", 64'(n_in - in0), 64'd2);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    check("bp_z_hold0", {56'd0, z}, {56'd0, first_exp});
    repeat (3) @(posedge cp);
    #2;
    check("bp_z_hold1", {56'd0, z}, {56'd0, first_exp});
    check("bp_accepts_hold", 64'(n_in - in0), 64'd2);
    out0 = n_out;
    out_ready = 1'b1;
    repeat (5) @(posedge cp);
    #2;
    check("bp_back_to_back", 64'(n_out - out0), 64'd5);
    wait fork;
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two beats in flight and a beat offered during reset.
    @(posedge cp);
    #1;
    out_ready = 1'b0;
    send(32'h1234_5678, 1'b0);
    send(32'h8000_0001, 1'b1);
    a_in = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge cp);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    out0 = n_out;
    repeat (6) @(posedge cp);
    #2;
    check("midrst_no_output", 64'(n_out - out0), 64'd0);

    // Random stream with random consumer stalls.
    bp_stop = 1'b0;
    fork
      while (!bp_stop) begin
        @(posedge cp);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int i = 0; i < 24; i++) send($urandom, 1'($urandom_range(0, 1)));
    bp_stop = 1'b1;
    wait fork;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge cp);
    #2;
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // Odd configuration, exhaustive, latency 1.
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 8; v++) begin
        a3 = 3'(v);
        mode3 = 1'(m);
        in_valid3 = 1'b1;
        @(negedge cp);
        check("odd_in_ready", {63'd0, in_ready3}, 64'd1);
        @(posedge cp);
        #1;
        in_valid3 = 1'b0;
        check("odd_valid", {63'd0, out_valid3}, 64'd1);
        check("odd_z", {63'd0, z3}, (m == 1) ? 64'(v != 0) : 64'(v == 0));
      end
    end
    @(posedge cp);
    #1;
    check("odd_idle", {63'd0, out_valid3}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
